micro_sequencer: RTL

- Owns the micro-program counter (uPC) that addresses the 76-entry microcode control store.
- Each cycle it selects the next uPC from the next-address field of the current microinstruction, with run/stall/single-step gating.
- Detects the end-of-program bit, enforces a micro-step watchdog, and flags out-of-range addresses.
- Sits between the control store output (MIR) and the control store address input. It replaces the free-running address feedback.

---
 rtl/micro_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/micro_sequencer.sv
// micro_sequencer: uPC sequencer for the microcode control store; define USEQ_TRACE_EN for retire trace outputs
module micro_sequencer #(
  parameter int ADDR_W     = 9,
  parameter int ROM_DEPTH  = 76,
  parameter int ENTRY_ADDR = 0,
  parameter int MAX_USTEPS = 65535,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  input  logic              step_mode,
  input  logic              step,
  input  logic [ADDR_W-1:0] next_addr,
  input  logic              end_flag,
  output logic [ADDR_W-1:0] upc,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic              bad_addr,
  output logic [CNT_W-1:0]  ucount
`ifdef USEQ_TRACE_EN
  ,
  output logic              trace_valid,
  output logic [ADDR_W-1:0] trace_addr
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] upc_n;
  logic [CNT_W-1:0] cnt_n;
  logic to_n, bad_n, step_q, adv, oob, wd;
  assign adv = !stall && (!step_mode || (step && !step_q));
  assign oob = next_addr >= ADDR_W'(ROM_DEPTH);
  assign wd = ucount == CNT_W'(MAX_USTEPS - 1);
  assign running = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    upc_n = upc;
    cnt_n = ucount;
    to_n = timeout;
    bad_n = bad_addr;
    if (abort) begin
      state_n = IDLE;
      upc_n = ADDR_W'(ENTRY_ADDR);
      cnt_n = '0;
      to_n = 1'b0;
      bad_n = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state_n = RUN;
          upc_n = ADDR_W'(ENTRY_ADDR);
          cnt_n = '0;
        end
        RUN: if (adv) begin
          // end_flag outranks both faults, so next_addr is don't-care on the last word
          if (end_flag) begin
            state_n = DONE;
            upc_n = ADDR_W'(ENTRY_ADDR);
            cnt_n = ucount + 1'b1;
          end else if (oob) begin
            state_n = FAULT;
            bad_n = 1'b1;
          end else if (wd) begin
            state_n = FAULT;
            to_n = 1'b1;
            cnt_n = CNT_W'(MAX_USTEPS);
          end else begin
            upc_n = next_addr;
            cnt_n = ucount + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      upc <= ADDR_W'(ENTRY_ADDR);
      ucount <= '0;
      timeout <= 1'b0;
      bad_addr <= 1'b0;
      step_q <= 1'b0;
    end else begin
      state <= state_n;
      upc <= upc_n;
      ucount <= cnt_n;
      timeout <= to_n;
      bad_addr <= bad_n;
      step_q <= step;
    end
  end
`ifdef USEQ_TRACE_EN
  logic retire;
  assign retire = !abort && state == RUN && adv && (end_flag || (!oob && !wd));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_valid <= 1'b0;
      trace_addr <= '0;
    end else begin
      trace_valid <= retire;
      trace_addr <= retire ? upc : (state_n == RUN || state_n == DONE) ? trace_addr : '0;
    end
  end
`endif
endmodule
